// File: rtl/dpll_pkg.sv
// dpll_pkg: shared state encoding and default gain constants for the DPLL loop gain scheduler.
// Rev 1.0
`default_nettype none

package dpll_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_ACQ   = 2'd2,
      ST_TRACK = 2'd3
   } state_t;

   localparam int DEF_MULT_W   = 8;
   localparam int DEF_ACQ_GAIN = 64;
   localparam int DEF_TRK_GAIN = 8;

   // States in which the phase-detector stream is being watched and the filter is running.
   function automatic logic obs_state(state_t s);
      return (s == ST_ACQ) || (s == ST_TRACK);
   endfunction

endpackage

`default_nettype wire

// File: rtl/toggle_window_counter.sv
// toggle_window_counter: counts phase-detector toggles over fixed-length observation windows.
// Rev 1.0
`default_nettype none

module toggle_window_counter #(
   parameter int WIN_LEN = 64,
   parameter int CNT_MAX = 16,
   parameter int TOG_W   = $clog2(CNT_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             clear,
   input  logic             pd_in,
   output logic             win_end,
   output logic [TOG_W-1:0] win_tog
);

   localparam int WIN_W = $clog2(WIN_LEN);

   logic             r_pd_d;
   logic [WIN_W-1:0] r_win_cnt;
   logic [TOG_W-1:0] r_tog_cnt;
   logic             w_toggle;

   assign w_toggle = pd_in ^ r_pd_d;
   assign win_end  = run && (r_win_cnt == WIN_W'(WIN_LEN - 1));

   // Includes the current cycle's toggle so a window end sees the complete count.
   always_comb begin
      win_tog = r_tog_cnt;
      if (run && w_toggle && (r_tog_cnt != TOG_W'(CNT_MAX))) begin
         win_tog = r_tog_cnt + TOG_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pd_d    <= 1'b0;
         r_win_cnt <= '0;
         r_tog_cnt <= '0;
      end else begin
         r_pd_d <= pd_in;
         if (clear || win_end) begin
            r_win_cnt <= '0;
            r_tog_cnt <= '0;
         end else if (run) begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
            r_tog_cnt <= win_tog;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/loop_gain_scheduler.sv
// loop_gain_scheduler: acquisition/tracking gain sequencer driving the DPLL FIR loop filter.
// Rev 1.0
`default_nettype none

module loop_gain_scheduler
   import dpll_pkg::*;
#(
   parameter int MULT_W     = DEF_MULT_W,
   parameter int ACQ_GAIN   = DEF_ACQ_GAIN,
   parameter int TRK_GAIN   = DEF_TRK_GAIN,
   parameter int WIN_LEN    = 64,
   parameter int FLUSH_CYC  = 16,
   parameter int LOCK_THR   = 4,
   parameter int LOCK_WINS  = 4,
   parameter int UNLOCK_THR = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              freeze,
   input  logic              pd_in,
   output logic [MULT_W-1:0] multiplier,
   output logic              fir_rst_n,
   output logic              locked,
   output logic              gain_upd,
   output logic [1:0]        state
);

   localparam int TOG_W = $clog2(UNLOCK_THR + 1);
   localparam int FL_W  = $clog2(FLUSH_CYC + 1);
   localparam int QT_W  = $clog2(LOCK_WINS + 1);

   localparam logic [MULT_W-1:0] c_acq_word = MULT_W'(ACQ_GAIN);
   localparam logic [MULT_W-1:0] c_trk_word = MULT_W'(TRK_GAIN);

   state_t           r_state;
   state_t           w_next;
   logic [FL_W-1:0]  r_flush_cnt;
   logic [QT_W-1:0]  r_quiet_cnt;
   logic [QT_W-1:0]  w_quiet_next;
   logic             w_run;
   logic             w_clear;
   logic             w_win_end;
   logic [TOG_W-1:0] w_win_tog;

   function automatic logic [MULT_W-1:0] gain_of(state_t s);
      case (s)
         ST_FLUSH, ST_ACQ: gain_of = c_acq_word;
         ST_TRACK:         gain_of = c_trk_word;
         default:          gain_of = '0;
      endcase
   endfunction

   assign w_run   = obs_state(r_state) && !freeze;
   assign w_clear = (w_next != r_state);

   toggle_window_counter #(
      .WIN_LEN (WIN_LEN),
      .CNT_MAX (UNLOCK_THR),
      .TOG_W   (TOG_W)
   ) u_twc (
      .clk     (clk),
      .rst     (rst),
      .run     (w_run),
      .clear   (w_clear),
      .pd_in   (pd_in),
      .win_end (w_win_end),
      .win_tog (w_win_tog)
   );

   // Disable wins over everything, including a coincident window end.
   always_comb begin
      w_next       = r_state;
      w_quiet_next = r_quiet_cnt;
      if (!en) begin
         w_next       = ST_IDLE;
         w_quiet_next = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_next = ST_FLUSH;
            end
            ST_FLUSH: begin
               if (r_flush_cnt == FL_W'(FLUSH_CYC - 1)) begin
                  w_next = ST_ACQ;
               end
            end
            ST_ACQ: begin
               if (w_win_end) begin
                  if (w_win_tog <= TOG_W'(LOCK_THR)) begin
                     if (r_quiet_cnt == QT_W'(LOCK_WINS - 1)) begin
                        w_next       = ST_TRACK;
                        w_quiet_next = '0;
                     end else begin
                        w_quiet_next = r_quiet_cnt + QT_W'(1);
                     end
                  end else begin
                     w_quiet_next = '0;
                  end
               end
            end
            ST_TRACK: begin
               if (w_win_end && (w_win_tog >= TOG_W'(UNLOCK_THR))) begin
                  w_next = ST_ACQ;
               end
            end
            default: begin
               w_next = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they move on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= '0;
         r_quiet_cnt <= '0;
         multiplier  <= '0;
         fir_rst_n   <= 1'b0;
         locked      <= 1'b0;
         gain_upd    <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_quiet_cnt <= w_quiet_next;
         if ((r_state == ST_FLUSH) && (w_next == ST_FLUSH)) begin
            r_flush_cnt <= r_flush_cnt + FL_W'(1);
         end else begin
            r_flush_cnt <= '0;
         end
         multiplier <= gain_of(w_next);
         fir_rst_n  <= obs_state(w_next);
         locked     <= (w_next == ST_TRACK);
         gain_upd   <= (gain_of(w_next) != multiplier) && (gain_of(w_next) != '0);
      end
   end

   assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_loop_gain_scheduler.sv
// tb_loop_gain_scheduler: directed scenarios plus randomized traffic against a behavioural model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_loop_gain_scheduler;

   localparam int MULT_W     = 8;
   localparam int ACQ_GAIN   = 64;
   localparam int TRK_GAIN   = 8;
   localparam int WIN_LEN    = 8;
   localparam int FLUSH_CYC  = 4;
   localparam int LOCK_THR   = 1;
   localparam int LOCK_WINS  = 2;
   localparam int UNLOCK_THR = 4;

   logic              clk    = 1'b0;
   logic              rst    = 1'b1;
   logic              en     = 1'b0;
   logic              freeze = 1'b0;
   logic              pd_in  = 1'b0;
   logic [MULT_W-1:0] multiplier;
   logic              fir_rst_n;
   logic              locked;
   logic              gain_upd;
   logic [1:0]        state;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: state number, cycles spent in flush, running cycles and raw toggles in the current window.
   int m_st = 0, m_flush = 0, m_win = 0, m_tog = 0, m_quiet = 0, m_pdd = 0, m_upd = 0;

   loop_gain_scheduler #(
      .MULT_W     (MULT_W),
      .ACQ_GAIN   (ACQ_GAIN),
      .TRK_GAIN   (TRK_GAIN),
      .WIN_LEN    (WIN_LEN),
      .FLUSH_CYC  (FLUSH_CYC),
      .LOCK_THR   (LOCK_THR),
      .LOCK_WINS  (LOCK_WINS),
      .UNLOCK_THR (UNLOCK_THR)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .freeze     (freeze),
      .pd_in      (pd_in),
      .multiplier (multiplier),
      .fir_rst_n  (fir_rst_n),
      .locked     (locked),
      .gain_upd   (gain_upd),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gain_of(input int s);
      if (s == 1 || s == 2) return ACQ_GAIN;
      if (s == 3) return TRK_GAIN;
      return 0;
   endfunction

   task automatic model_step();
      int ns;
      int tog;
      if (rst) begin
         m_st = 0; m_flush = 0; m_win = 0; m_tog = 0; m_quiet = 0; m_pdd = 0; m_upd = 0;
      end else begin
         tog   = (int'(pd_in) != m_pdd) ? 1 : 0;
         m_pdd = int'(pd_in);
         ns    = m_st;
         if (!en) begin
            ns = 0;
         end else if (m_st == 0) begin
            ns = 1;
         end else if (m_st == 1) begin
            m_flush++;
            if (m_flush == FLUSH_CYC) ns = 2;
         end else if (!freeze) begin
            m_win++;
            m_tog += tog;
            if (m_win == WIN_LEN) begin
               if (m_st == 2) begin
                  m_quiet = (m_tog <= LOCK_THR) ? m_quiet + 1 : 0;
                  if (m_quiet == LOCK_WINS) begin
                     ns      = 3;
                     m_quiet = 0;
                  end
               end else if (m_tog >= UNLOCK_THR) begin
                  ns = 2;
               end
               m_win = 0;
               m_tog = 0;
            end
         end
         if (ns != m_st) begin
            m_win = 0; m_tog = 0; m_flush = 0;
         end
         if (ns == 0) m_quiet = 0;
         m_upd = (gain_of(ns) != gain_of(m_st) && gain_of(ns) != 0) ? 1 : 0;
         m_st  = ns;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("state",      int'(state),      m_st);
         chk("multiplier", int'(multiplier), gain_of(m_st));
         chk("fir_rst_n",  int'(fir_rst_n),  (m_st >= 2) ? 1 : 0);
         chk("locked",     int'(locked),     (m_st == 3) ? 1 : 0);
         chk("gain_upd",   int'(gain_upd),   m_upd);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pin(input string tag, input int st, input int mul, input int frn, input int lck, input int upd);
      chk({tag, ".state"},      int'(state),      st);
      chk({tag, ".multiplier"}, int'(multiplier), mul);
      chk({tag, ".fir_rst_n"},  int'(fir_rst_n),  frn);
      chk({tag, ".locked"},     int'(locked),     lck);
      chk({tag, ".gain_upd"},   int'(gain_upd),   upd);
   endtask

   // One TRACK window with a toggle every cycle; expected to fall back to ACQ at its end.
   task automatic busy_window();
      for (int i = 0; i < WIN_LEN - 1; i++) begin
         pd_in = ~pd_in;
         cyc(1);
      end
      chk("busy.mid_window", int'(state), 3);
      pd_in = ~pd_in;
      cyc(1);
      pin("unlock", 2, 64, 1, 0, 1);
   endtask

   initial begin
      int p_mode;
      p_mode = 0;
      cyc(2);
      pin("reset", 0, 0, 0, 0, 0);

      rst = 1'b0;
      en  = 1'b1;
      cyc(1);
      pin("flush_entry", 1, 64, 0, 0, 1);
      cyc(1);
      pin("flush_hold", 1, 64, 0, 0, 0);
      cyc(3);
      pin("acq_entry", 2, 64, 1, 0, 0);

      cyc(15);
      chk("quiet.before_lock", int'(state), 2);
      cyc(1);
      pin("lock", 3, 8, 1, 1, 1);

      busy_window();

      for (int w = 0; w < 4; w++) begin
         for (int c = 0; c < WIN_LEN; c++) begin
            if (w == 1 && (c == 1 || c == 3 || c == 5)) pd_in = ~pd_in;
            cyc(1);
         end
         if (w == 2) chk("mixed.after_w3", int'(state), 2);
      end
      pin("mixed.lock", 3, 8, 1, 1, 1);

      busy_window();
      cyc(3);
      freeze = 1'b1;
      for (int i = 0; i < 20; i++) begin
         pd_in = ~pd_in;
         cyc(1);
      end
      chk("freeze.state", int'(state), 2);
      freeze = 1'b0;
      cyc(12);
      chk("freeze.resume_acq", int'(state), 2);
      cyc(1);
      pin("freeze.lock", 3, 8, 1, 1, 1);

      cyc(5);
      en = 1'b0;
      cyc(1);
      pin("disable", 0, 0, 0, 0, 0);
      en = 1'b1;
      cyc(2);
      chk("reflush", int'(state), 1);
      rst = 1'b1;
      #1;
      pin("async_rst", 0, 0, 0, 0, 0);
      cyc(1);
      rst = 1'b0;

      for (int i = 0; i < 3000; i++) begin
         if (i % 40 == 0) p_mode = $urandom_range(0, 3);
         en     = ($urandom_range(0, 199) != 0);
         freeze = ($urandom_range(0, 9) == 0);
         rst    = ($urandom_range(0, 999) == 0);
         case (p_mode)
            1:       if ($urandom_range(0, 15) == 0) pd_in = ~pd_in;
            2:       if ($urandom_range(0, 2) == 0) pd_in = ~pd_in;
            3:       pd_in = ~pd_in;
            default: pd_in = pd_in;
         endcase
         cyc(1);
      end
      rst = 1'b0;
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/loop_gain_scheduler.md
Name: loop_gain_scheduler

Overview:
Gain-scheduling sequencer for the DPLL loop filter. It drives the FIR filter's `multiplier` gain input and its active-low flush/reset. It watches the 1-bit phase-detector stream that feeds the filter and applies a high acquisition gain until the loop is quiet, then drops to a low tracking gain. If the phase error becomes busy again, it returns to acquisition gain.

Parameters:
- MULT_W, 8, width of the gain word driven to the filter multiplier.
- ACQ_GAIN, 64, gain applied during FLUSH and ACQ.
- TRK_GAIN, 8, gain applied during TRACK.
- WIN_LEN, 64, observation window length in cycles (≥2).
- FLUSH_CYC, 16, cycles the filter is held in reset when leaving IDLE (≥1).
- LOCK_THR, 4, max toggles in a window for that window to count as quiet.
- LOCK_WINS, 4, consecutive quiet windows needed to declare lock (≥1).
- UNLOCK_THR, 16, toggles in one window that force loss of lock (> LOCK_THR).

Ports:
- clk, in, 1, system clock; all state changes on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, loop enable.
- freeze, in, 1, hold the current gain and state; pauses the window and quiet counters.
- pd_in, in, 1, phase-detector bit (the same signal as the filter data input).
- multiplier, out, MULT_W, gain word to the filter.
- fir_rst_n, out, 1, active-low reset to the filter.
- locked, out, 1, lock indicator.
- gain_upd, out, 1, one-cycle pulse in the cycle `multiplier` takes a new nonzero value.
- state, out, 2, current state encoding.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - state=IDLE, multiplier=0, fir_rst_n=0, locked=0, gain_upd=0.
  - All counters=0, pd_d=0.
  - Reset asserted mid-operation aborts immediately to these values.
- All outputs are registered and decoded from next-state: an output change is visible in the same cycle the state changes.
- Toggle: a cycle where `pd_in != pd_d`. `pd_d` is a registered copy of `pd_in`, updated every cycle including during freeze.
- tog_cnt counts toggles while in ACQ/TRACK with freeze=0. It saturates at UNLOCK_THR.
- win_cnt runs 0..WIN_LEN-1 in ACQ/TRACK with freeze=0. It is cleared on any state change.
- Window end is the cycle with win_cnt=WIN_LEN-1 and freeze=0:
  - evaluation uses the toggle count including that cycle's toggle;
  - tog_cnt and win_cnt then clear.
- States: IDLE=0, FLUSH=1, ACQ=2, TRACK=3.
- IDLE:
  - multiplier=0, fir_rst_n=0, locked=0.
  - en=1 → FLUSH on the next edge.
- FLUSH:
  - multiplier=ACQ_GAIN, fir_rst_n=0, gain_upd pulses on entry.
  - Lasts exactly FLUSH_CYC cycles, then → ACQ. freeze is ignored in FLUSH.
- ACQ:
  - multiplier=ACQ_GAIN, fir_rst_n=1.
  - At window end: count ≤ LOCK_THR → quiet_cnt++; otherwise quiet_cnt=0.
  - When quiet_cnt reaches LOCK_WINS → TRACK. On entry: multiplier=TRK_GAIN, locked=1, gain_upd=1, quiet_cnt=0.
- TRACK:
  - At window end with count ≥ UNLOCK_THR → ACQ. On entry: multiplier=ACQ_GAIN, locked=0, gain_upd=1.
  - No filter flush on this transition.
  - Otherwise stay in TRACK.
- en=0 in any state → IDLE on the next edge, with multiplier=0 and fir_rst_n=0. gain_upd does not pulse. This takes priority over every other transition, including window end.
- freeze=1 in ACQ/TRACK:
  - State, multiplier and locked are held.
  - win_cnt, tog_cnt and quiet_cnt are held.
- A window end coinciding with freeze=1 cannot occur, because freeze blocks the window end.
- Lock and unlock are evaluated only at window ends, never mid-window.

Decomposition:
- Package `dpll_pkg`:
  - state enum (IDLE/FLUSH/ACQ/TRACK with the 2-bit encodings above);
  - default gain constants ACQ_GAIN and TRK_GAIN;
  - MULT_W.
- One sub-module, `toggle_window_counter`:
  - contains pd_d, win_cnt and the saturating tog_cnt;
  - takes `run` and `clear` inputs;
  - outputs `win_end` and `win_tog`.
- The FSM, quiet_cnt, flush counter and output registers live in `loop_gain_scheduler`.

Test Plan:
All scenarios use bench parameters WIN_LEN=8, FLUSH_CYC=4, LOCK_THR=1, LOCK_WINS=2, UNLOCK_THR=4, ACQ_GAIN=64, TRK_GAIN=8.

1. Reset then en=1: cycle 1 gives state=1, multiplier=64, fir_rst_n=0, gain_upd=1 for one cycle. After 4 cycles, state=2 and fir_rst_n=1.
2. ACQ with pd_in held constant for 16 cycles: after the 2nd window end, state=3, multiplier=8, locked=1, gain_upd pulse.
3. TRACK with pd_in toggling every cycle: at the next window end, state=2, multiplier=64, locked=0, gain_upd pulse, and fir_rst_n stays 1.
4. ACQ with windows of 0 toggles, then 3 toggles, then 0, then 0 toggles: lock is declared only after the 4th window (quiet_cnt resets on the busy window).
5. freeze=1 for 20 cycles in ACQ with pd_in toggling: no state change and counters held. After release, lock timing resumes from the held win_cnt.
6. en=0 mid-TRACK (win_cnt=5): next edge gives state=0, multiplier=0, fir_rst_n=0, locked=0, no gain_upd. rst=1 asynchronously in FLUSH gives all outputs at their reset values without a clock edge.
